// File: rtl/lock_sequencer.sv
// lock_sequencer: 3-digit code lock FSM with retry limit and timed lockout
module lock_sequencer #(
  parameter logic [11:0] CODE = 12'h619,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press,
  input  logic [3:0] digit,
  input  logic       relock,
  output logic [1:0] digit_idx,
  output logic [2:0] digit_we,
  output logic       unlocked,
  output logic       lockout,
  output logic       fail,
  output logic [1:0] tries_left,
  output logic [3:0] status_code
);
  localparam int TW = $clog2(LOCKOUT_CYCLES);
  localparam logic [1:0] MT = 2'(MAX_TRIES);
  typedef enum logic [1:0] {ENTRY, CHECK, UNLOCKED, LOCKOUT} state_t;
  state_t state;
  logic [11:0] entry;
  logic [TW-1:0] timer;
  logic take;
  // A digit is accepted only while entering, and relock or reset discards it
  always_comb begin
    take = !reset && state == ENTRY && press && !relock;
    digit_we = take ? 3'(3'b001 << digit_idx) : 3'b000;
    unlocked = state == UNLOCKED;
    lockout = state == LOCKOUT;
    status_code = unlocked ? 4'hC : lockout ? 4'hE : 4'hF;
  end
  // Sequencer: digit collection, code check, retry accounting and lockout timer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ENTRY;
      digit_idx <= 2'd0;
      entry <= 12'h000;
      tries_left <= MT;
      timer <= '0;
      fail <= 1'b0;
    end else begin
      fail <= 1'b0;
      case (state)
        ENTRY:
          if (relock) begin
            digit_idx <= 2'd0;
            entry <= 12'h000;
          end else if (press) begin
            case (digit_idx)
              2'd0: entry[11:8] <= digit;
              2'd1: entry[7:4] <= digit;
              default: entry[3:0] <= digit;
            endcase
            digit_idx <= digit_idx == 2'd2 ? 2'd0 : digit_idx + 2'd1;
            if (digit_idx == 2'd2) state <= CHECK;
          end
        CHECK:
          if (entry == CODE) begin
            state <= UNLOCKED;
            tries_left <= MT;
          end else begin
            fail <= 1'b1;
            tries_left <= tries_left != 2'd0 ? tries_left - 2'd1 : 2'd0;
            state <= tries_left <= 2'd1 ? LOCKOUT : ENTRY;
            timer <= TW'(LOCKOUT_CYCLES - 1);
            entry <= 12'h000;
          end
        UNLOCKED:
          if (relock) begin
            state <= ENTRY;
            digit_idx <= 2'd0;
            entry <= 12'h000;
          end
        LOCKOUT:
          if (timer == '0) begin
            state <= ENTRY;
            tries_left <= MT;
            digit_idx <= 2'd0;
            entry <= 12'h000;
          end else begin
            timer <= timer - 1'b1;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed and random checks of lock_sequencer against a digit-list model
module tb_lock_sequencer;
  localparam int LC = 10;
  localparam logic [11:0] CODE = 12'h619;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic press = 1'b0;
  logic [3:0] digit = 4'h0;
  logic relock = 1'b0;
  logic [1:0] digit_idx;
  logic [2:0] digit_we;
  logic unlocked, lockout, fail;
  logic [1:0] tries_left;
  logic [3:0] status_code;
  int ncmp = 0;
  int nerr = 0;
  int nd = 0;
  logic [3:0] dg [3];
  bit checking = 0;
  bit open = 0;
  int lock_left = 0;
  int tries = 3;
  bit fail_m = 0;

  lock_sequencer #(.CODE(CODE), .MAX_TRIES(3), .LOCKOUT_CYCLES(LC)) dut (
    .clk(clk), .reset(reset), .press(press), .digit(digit), .relock(relock),
    .digit_idx(digit_idx), .digit_we(digit_we), .unlocked(unlocked), .lockout(lockout),
    .fail(fail), .tries_left(tries_left), .status_code(status_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the load strobe, clock, advance the model, check outputs
  task automatic step(input logic p, input logic [3:0] d, input logic r, input logic rs);
    logic [2:0] we_exp;
    press = p;
    digit = d;
    relock = r;
    reset = rs;
    #1;
    we_exp = (!rs && !checking && !open && lock_left == 0 && p && !r) ? 3'(1 << nd) : 3'b000;
    chk("digit_we", 12'(digit_we), 12'(we_exp));
    @(posedge clk);
    fail_m = 0;
    if (rs) begin
      nd = 0; checking = 0; open = 0; lock_left = 0; tries = 3;
    end else if (checking) begin
      checking = 0;
      if ({dg[0], dg[1], dg[2]} == CODE) begin
        open = 1; tries = 3;
      end else begin
        fail_m = 1; tries--;
        if (tries == 0) lock_left = LC;
      end
    end else if (open) begin
      if (r) begin open = 0; nd = 0; end
    end else if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) begin tries = 3; nd = 0; end
    end else if (r) begin
      nd = 0;
    end else if (p) begin
      dg[nd] = d;
      nd++;
      if (nd == 3) begin nd = 0; checking = 1; end
    end
    #1;
    chk("digit_idx", 12'(digit_idx), 12'(nd));
    chk("unlocked", 12'(unlocked), 12'(open));
    chk("lockout", 12'(lockout), 12'(lock_left > 0));
    chk("fail", 12'(fail), 12'(fail_m));
    chk("tries_left", 12'(tries_left), 12'(tries));
    chk("status_code", 12'(status_code), open ? 12'hC : lock_left > 0 ? 12'hE : 12'hF);
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    step(1, a, 0, 0);
    step(1, b, 0, 0);
    step(1, c, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 1);
    step(1, 4'h6, 1, 1);
    chk("reset_status", 12'(status_code), 12'hF);
    enter(6, 1, 9);
    step(1, 6, 0, 0);
    chk("unlock_now", 12'(unlocked), 12'h1);
    chk("unlock_glyph", 12'(status_code), 12'hC);
    step(1, 9, 0, 0);
    step(0, 0, 1, 0);
    chk("relocked", 12'(unlocked), 12'h0);
    enter(6, 1, 8);
    step(0, 0, 0, 0);
    chk("fail_pulse", 12'(fail), 12'h1);
    chk("tries_two", 12'(tries_left), 12'h2);
    step(0, 0, 0, 0);
    chk("fail_gone", 12'(fail), 12'h0);
    enter(1, 1, 1);
    step(0, 0, 0, 0);
    enter(2, 2, 2);
    step(0, 0, 0, 0);
    chk("lockout_on", 12'(status_code), 12'hE);
    for (int i = 0; i < LC + 2; i++) step(1, 6, i[0], 0);
    chk("lockout_done", 12'(tries_left), 12'h3);
    chk("lockout_glyph", 12'(status_code), 12'hF);
    step(1, 6, 0, 0);
    step(1, 1, 0, 0);
    step(1, 9, 1, 0);
    chk("relock_idx", 12'(digit_idx), 12'h0);
    enter(6, 1, 9);
    step(0, 0, 0, 0);
    chk("unlock_after", 12'(unlocked), 12'h1);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      enter(3, 3, 3);
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 6, 1, 1);
    chk("reset_lockout", 12'(lockout), 12'h0);
    step(1, 6, 0, 0);
    step(1, 1, 0, 0);
    step(1, 6, 0, 1);
    chk("reset_entry", 12'(digit_idx), 12'h0);
    enter(6, 1, 9);
    step(0, 0, 0, 0);
    chk("reset_unlock", 12'(unlocked), 12'h1);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] d;
      int k;
      k = $urandom_range(0, 3);
      d = k == 0 ? 4'h6 : k == 1 ? 4'h1 : k == 2 ? 4'h9 : 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), d, $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
